dds_ramp_sequencer: RTL and testbench

- Next-generation AD9910 digital-ramp controller.
- On each rising edge of `io_update` it runs a burst of timed ramp windows.
- It drives `drctl` according to a selectable sweep mode (up, down, triangle) and `drhold` to freeze the ramp between windows; `osk` gates the output amplitude.
- It sits between the host command decoder, which supplies the window width, mode and burst count, and the DDS control pins. It replaces the fixed single-window, up/down-only controller.

---
 rtl/dds_ramp_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_dds_ramp_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dds_ramp_sequencer.sv
// rtl/dds_ramp_sequencer.sv - AD9910 digital-ramp burst sequencer (up/down/triangle windows, optional gap hold).
// Optional feature macro: DDS_OSK_DROVER_MASK_EN (blank osk while the DDS reports ramp-over).
module dds_ramp_sequencer #(
  parameter int CNT_W   = 16,
  parameter int REP_W   = 8,
  parameter int CLKNUM  = 2,
  parameter int GAP_CYC = 4
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             io_update,
  input  logic             drover,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] pulse_ns,
  input  logic [REP_W-1:0] burst_len,
  input  logic             abort,
  output logic             drctl,
  output logic             drhold,
  output logic             osk,
  output logic             busy,
  output logic             done,
  output logic [REP_W-1:0] win_cnt
);

  localparam int              GAP_W    = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] CLK_DIV  = CNT_W'(CLKNUM);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP} state_t;

  state_t           state, state_nx;
  logic [1:0]       io_sync;
  logic             trigger, load;
  logic [CNT_W-1:0] len, len_q, half, cnt, cnt_nx;
  logic [1:0]       mode_q;
  logic [REP_W-1:0] burst_q, win_nx;
  logic [GAP_W-1:0] gap_cnt, gap_nx;
  logic             done_flag, done_flag_nx;
  logic             win_end, burst_end, stop;
  logic             drctl_nx, drhold_nx, osk_nx, busy_nx;
  logic             run_gate;

  function automatic logic start_dir(input logic [1:0] m);
    return ~m[0];
  endfunction

  assign len     = pulse_ns / CLK_DIV;
  assign half    = len_q >> 1;
  assign trigger = io_sync[0] & ~io_sync[1];
  assign load    = (state == S_IDLE) && trigger && (len != '0);
  assign stop    = abort && (state != S_IDLE);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) io_sync <= 2'b00;
    else         io_sync <= {io_sync[0], io_update};
  end

`ifdef DDS_OSK_DROVER_MASK_EN
  logic [1:0] dr_sync;
  always_ff @(posedge sys_clk) begin
    if (sys_rst) dr_sync <= 2'b00;
    else         dr_sync <= {dr_sync[0], drover};
  end
  assign run_gate = ~dr_sync[1];
`else
  logic unused_drover;
  assign unused_drover = drover;
  assign run_gate      = 1'b1;
`endif

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    gap_nx       = gap_cnt;
    win_nx       = win_cnt;
    done_flag_nx = 1'b0;
    win_end      = (state == S_RUN) && (cnt == len_q - CNT_W'(1));
    burst_end    = win_end && (burst_q != '0) && (win_cnt + REP_W'(1) == burst_q);
    case (state)
      S_IDLE: begin
        if (load) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
          win_nx   = '0;
        end
      end
      S_RUN: begin
        cnt_nx = cnt + CNT_W'(1);
        if (win_end) begin
          win_nx = win_cnt + REP_W'(1);
          cnt_nx = '0;
          if (burst_end) begin
            state_nx     = S_IDLE;
            done_flag_nx = 1'b1;
          end else if (GAP_CYC == 0) begin
            state_nx = S_RUN;
          end else begin
            state_nx = S_GAP;
            gap_nx   = '0;
          end
        end
      end
      S_GAP: begin
        gap_nx = gap_cnt + GAP_W'(1);
        if (gap_cnt == GAP_LAST) begin
          state_nx = S_RUN;
          cnt_nx   = '0;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // Abort outranks window end: counters and win_cnt freeze, no done.
    if (stop) begin
      state_nx     = S_IDLE;
      cnt_nx       = cnt;
      win_nx       = win_cnt;
      done_flag_nx = 1'b0;
    end
  end

  // Pin values follow the state one cycle later, except abort which forces idle pins at once.
  always_comb begin
    drctl_nx  = start_dir(mode);
    drhold_nx = 1'b1;
    osk_nx    = 1'b0;
    busy_nx   = 1'b0;
    case (state)
      S_RUN: begin
        drhold_nx = 1'b0;
        osk_nx    = run_gate;
        busy_nx   = 1'b1;
        case (mode_q)
          2'b00:   drctl_nx = 1'b1;
          2'b01:   drctl_nx = 1'b0;
          2'b10:   drctl_nx = (cnt < half);
          default: drctl_nx = (cnt >= half);
        endcase
      end
      S_GAP: begin
        busy_nx  = 1'b1;
        drctl_nx = start_dir(mode_q);
      end
      default: ;
    endcase
    if (stop) begin
      drctl_nx  = start_dir(mode);
      drhold_nx = 1'b1;
      osk_nx    = 1'b0;
      busy_nx   = 1'b0;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      win_cnt   <= '0;
      done_flag <= 1'b0;
      len_q     <= '0;
      mode_q    <= 2'b00;
      burst_q   <= '0;
      drctl     <= 1'b0;
      drhold    <= 1'b1;
      osk       <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gap_cnt   <= gap_nx;
      win_cnt   <= win_nx;
      done_flag <= done_flag_nx;
      if (load) begin
        len_q   <= len;
        mode_q  <= mode;
        burst_q <= burst_len;
      end
      drctl  <= drctl_nx;
      drhold <= drhold_nx;
      osk    <= osk_nx;
      busy   <= busy_nx;
      done   <= done_flag && !stop;
    end
  end

endmodule

// File: tb/tb_dds_ramp_sequencer.sv
// tb/tb_dds_ramp_sequencer.sv - directed self-checking bench for dds_ramp_sequencer (default parameters).
module tb_dds_ramp_sequencer;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        io_update = 1'b0;
  logic        drover = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [15:0] pulse_ns = 16'd20;
  logic [7:0]  burst_len = 8'd1;
  logic        abort = 1'b0;
  logic        drctl, drhold, osk, busy, done;
  logic [7:0]  win_cnt;

  int passed = 0;
  int total  = 0;

  logic       s_osk [0:63];
  logic       s_drctl [0:63];
  logic       s_busy [0:63];
  logic       s_drhold [0:63];
  logic       s_done [0:63];
  logic [7:0] s_win [0:63];

  int         retrig_at, abort_at, rst_at, mode_at, drover_at;
  logic [1:0] mode_new;

  always #1 sys_clk = ~sys_clk;

  dds_ramp_sequencer dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .io_update(io_update), .drover(drover),
    .mode(mode), .pulse_ns(pulse_ns), .burst_len(burst_len), .abort(abort),
    .drctl(drctl), .drhold(drhold), .osk(osk), .busy(busy), .done(done), .win_cnt(win_cnt)
  );

  task automatic clear_knobs();
    retrig_at = -1; abort_at = -1; rst_at = -1; mode_at = -1; drover_at = -1; mode_new = 2'b00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge sys_clk);
  endtask

  // Sample i is taken at the falling edge after rising edge k+i, where edge k first sees io_update high.
  task automatic capture(input int n, input bit fire);
    if (fire) begin
      @(negedge sys_clk);
      io_update = 1'b1;
    end
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk);
      s_osk[i] = osk; s_drctl[i] = drctl; s_busy[i] = busy;
      s_drhold[i] = drhold; s_done[i] = done; s_win[i] = win_cnt;
      if (i == 3) io_update = 1'b0;
      if (retrig_at >= 0 && i == retrig_at) io_update = 1'b1;
      if (retrig_at >= 0 && i == retrig_at + 3) io_update = 1'b0;
      abort   = (i == abort_at);
      sys_rst = (i == rst_at);
      if (i == mode_at) mode = mode_new;
      drover  = (drover_at >= 0) && (i >= drover_at) && (i < drover_at + 3);
    end
    io_update = 1'b0; abort = 1'b0; sys_rst = 1'b0; drover = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    idle(3);
    total++; if (drctl !== 1'b0)  $display("FAIL reset_drctl got %b want 0", drctl);   else passed++;
    total++; if (drhold !== 1'b1) $display("FAIL reset_drhold got %b want 1", drhold); else passed++;
    total++; if (osk !== 1'b0)    $display("FAIL reset_osk got %b want 0", osk);       else passed++;
    total++; if (busy !== 1'b0)   $display("FAIL reset_busy got %b want 0", busy);     else passed++;
    total++; if (done !== 1'b0)   $display("FAIL reset_done got %b want 0", done);     else passed++;
    total++; if (win_cnt !== 8'd0) $display("FAIL reset_win_cnt got %0d want 0", win_cnt); else passed++;
    sys_rst = 1'b0;
    idle(3);
    total++; if (drctl !== 1'b1) $display("FAIL idle_drctl_up got %b want 1", drctl); else passed++;
  endtask

  task automatic test_up();
    int err = 0, n_done = 0;
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd20; burst_len = 8'd1;
    capture(20, 1'b1);
    total++; if (s_busy[1] !== 1'b0 || s_busy[2] !== 1'b1)
      $display("FAIL up_latency busy[1]=%b busy[2]=%b want 0,1", s_busy[1], s_busy[2]); else passed++;
    for (int i = 0; i < 20; i++) begin
      logic exp_run;
      exp_run = (i >= 2) && (i < 12);
      if (s_osk[i] !== exp_run || s_drhold[i] !== !exp_run) err++;
      if (exp_run && s_drctl[i] !== 1'b1) err++;
      if (s_done[i] === 1'b1) n_done++;
    end
    total++; if (err != 0) $display("FAIL up_window bad_samples=%0d want 0", err); else passed++;
    total++; if (n_done != 1 || s_done[12] !== 1'b1)
      $display("FAIL up_done count=%0d done[12]=%b want 1,1", n_done, s_done[12]); else passed++;
    total++; if (s_win[13] !== 8'd1) $display("FAIL up_win_cnt got %0d want 1", s_win[13]); else passed++;
    idle(4);
  endtask

  task automatic test_triangle();
    int err_up = 0, err_dn = 0, err_down_mode = 0;
    clear_knobs();
    pulse_ns = 16'd22; burst_len = 8'd1; mode = 2'b10;
    capture(16, 1'b1);
    for (int i = 2; i < 13; i++) if (s_drctl[i] !== ((i - 2) < 5) || s_osk[i] !== 1'b1) err_up++;
    total++; if (err_up != 0 || s_osk[13] !== 1'b0)
      $display("FAIL tri_up_first bad_samples=%0d osk[13]=%b want 0,0", err_up, s_osk[13]); else passed++;
    idle(4);
    mode = 2'b11;
    capture(16, 1'b1);
    for (int i = 2; i < 13; i++) if (s_drctl[i] !== ((i - 2) >= 5) || s_osk[i] !== 1'b1) err_dn++;
    total++; if (err_dn != 0) $display("FAIL tri_down_first bad_samples=%0d want 0", err_dn); else passed++;
    idle(4);
    mode = 2'b01;
    capture(16, 1'b1);
    for (int i = 2; i < 13; i++) if (s_drctl[i] !== 1'b0) err_down_mode++;
    total++; if (err_down_mode != 0) $display("FAIL down_mode bad_samples=%0d want 0", err_down_mode); else passed++;
    idle(4);
  endtask

  task automatic test_burst();
    int err_osk = 0, err_busy = 0, err_done = 0, err_dir = 0;
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd20; burst_len = 8'd3;
    mode_at = 1; mode_new = 2'b01;
    capture(45, 1'b1);
    for (int i = 0; i < 45; i++) begin
      logic exp_run, exp_busy;
      exp_run  = (i >= 2 && i < 12) || (i >= 16 && i < 26) || (i >= 30 && i < 40);
      exp_busy = (i >= 2) && (i < 40);
      if (s_osk[i] !== exp_run || s_drhold[i] !== !exp_run) err_osk++;
      if (s_busy[i] !== exp_busy) err_busy++;
      if (s_done[i] !== (i == 40)) err_done++;
      if (exp_busy && s_drctl[i] !== 1'b1) err_dir++;
    end
    total++; if (err_osk != 0)  $display("FAIL burst_windows bad_samples=%0d want 0", err_osk); else passed++;
    total++; if (err_busy != 0) $display("FAIL burst_busy bad_samples=%0d want 0", err_busy); else passed++;
    total++; if (err_done != 0) $display("FAIL burst_done bad_samples=%0d want 0", err_done); else passed++;
    total++; if (err_dir != 0)  $display("FAIL burst_latched_dir bad_samples=%0d want 0", err_dir); else passed++;
    total++; if (s_win[41] !== 8'd3) $display("FAIL burst_win_cnt got %0d want 3", s_win[41]); else passed++;
    total++; if (s_drctl[41] !== 1'b0) $display("FAIL burst_idle_live_dir got %b want 0", s_drctl[41]); else passed++;
    mode = 2'b00;
    idle(4);
  endtask

  task automatic test_zero_len_retrigger();
    int n_busy = 0, n_osk = 0, n_done = 0;
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd1; burst_len = 8'd1;
    capture(12, 1'b1);
    for (int i = 0; i < 12; i++) if (s_busy[i] !== 1'b0) n_busy++;
    total++; if (n_busy != 0) $display("FAIL zero_len_busy high_samples=%0d want 0", n_busy); else passed++;
    idle(4);
    pulse_ns = 16'd20;
    retrig_at = 5;
    capture(24, 1'b1);
    for (int i = 0; i < 24; i++) begin
      if (s_osk[i] === 1'b1) n_osk++;
      if (s_done[i] === 1'b1) n_done++;
    end
    total++; if (n_osk != 10 || s_osk[11] !== 1'b1 || s_osk[12] !== 1'b0)
      $display("FAIL retrigger_window osk_cycles=%0d want 10", n_osk); else passed++;
    total++; if (n_done != 1) $display("FAIL retrigger_done count=%0d want 1", n_done); else passed++;
    idle(4);
  endtask

  task automatic test_abort();
    int n_done = 0;
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd20; burst_len = 8'd0;
    abort_at = 20;
    capture(32, 1'b1);
    for (int i = 0; i < 32; i++) if (s_done[i] === 1'b1) n_done++;
    total++; if (s_busy[20] !== 1'b1 || s_osk[20] !== 1'b1)
      $display("FAIL abort_pre busy=%b osk=%b want 1,1", s_busy[20], s_osk[20]); else passed++;
    total++; if (s_busy[21] !== 1'b0 || s_drhold[21] !== 1'b1 || s_osk[21] !== 1'b0)
      $display("FAIL abort_stop busy=%b drhold=%b osk=%b want 0,1,0", s_busy[21], s_drhold[21], s_osk[21]); else passed++;
    total++; if (n_done != 0) $display("FAIL abort_no_done count=%0d want 0", n_done); else passed++;
    total++; if (s_win[21] !== 8'd1 || s_win[31] !== 8'd1)
      $display("FAIL abort_win_held got %0d,%0d want 1,1", s_win[21], s_win[31]); else passed++;
    total++; if (s_busy[31] !== 1'b0) $display("FAIL abort_stays_idle busy=%b want 0", s_busy[31]); else passed++;
    idle(4);
  endtask

  task automatic test_reset_mid_gap();
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd20; burst_len = 8'd0;
    rst_at = 12;
    capture(22, 1'b1);
    total++; if (s_busy[12] !== 1'b1 || s_drhold[12] !== 1'b1 || s_win[12] !== 8'd1)
      $display("FAIL rst_gap_pre busy=%b drhold=%b win=%0d want 1,1,1", s_busy[12], s_drhold[12], s_win[12]); else passed++;
    total++; if (s_drctl[13] !== 1'b0 || s_drhold[13] !== 1'b1 || s_osk[13] !== 1'b0 ||
                 s_busy[13] !== 1'b0 || s_done[13] !== 1'b0 || s_win[13] !== 8'd0)
      $display("FAIL rst_gap_values drctl=%b drhold=%b osk=%b busy=%b done=%b win=%0d want 0,1,0,0,0,0",
               s_drctl[13], s_drhold[13], s_osk[13], s_busy[13], s_done[13], s_win[13]); else passed++;
    total++; if (s_busy[21] !== 1'b0) $display("FAIL rst_gap_idle busy=%b want 0", s_busy[21]); else passed++;
    idle(4);
  endtask

  task automatic test_drover();
    int err = 0;
    clear_knobs();
    mode = 2'b00; pulse_ns = 16'd20; burst_len = 8'd1;
    drover_at = 5;
    capture(16, 1'b1);
    for (int i = 0; i < 16; i++) begin
      logic exp_osk;
`ifdef DDS_OSK_DROVER_MASK_EN
      exp_osk = (i >= 2) && (i < 12) && !(i >= 8 && i < 11);
`else
      exp_osk = (i >= 2) && (i < 12);
`endif
      if (s_osk[i] !== exp_osk) err++;
      if (s_drhold[i] !== !((i >= 2) && (i < 12))) err++;
    end
    total++; if (err != 0) $display("FAIL drover_osk bad_samples=%0d want 0", err); else passed++;
    idle(4);
  endtask

  initial begin
    clear_knobs();
    test_reset();
    test_up();
    test_triangle();
    test_burst();
    test_zero_len_retrigger();
    test_abort();
    test_reset_mid_gap();
    test_drover();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
